// File: rtl/fetch_seq_pkg.sv
// -----------------------------------------------------------------------------
// fetch_seq_pkg
// Shared types and constants for the fetch sequencer:
//   op_e     - decoded LOAD/STORE opcodes (values 5..7 are illegal)
//   state_e  - sequencer FSM states
//   PE_NUM   - number of processing elements fed by Data_Fetch
//   MASK_*   - PE_LOAD_EN masks for whole-array, row and column loads
// -----------------------------------------------------------------------------
package fetch_seq_pkg;

    localparam int PE_NUM = 4;

    typedef enum logic [2:0] {
        OP_LOAD_ALL = 3'd0,
        OP_LOAD_ONE = 3'd1,
        OP_LOAD_ROW = 3'd2,
        OP_LOAD_COL = 3'd3,
        OP_STORE    = 3'd4
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_e;

    localparam logic [PE_NUM-1:0] MASK_ALL  = 4'b1111;
    localparam logic [PE_NUM-1:0] MASK_ROW0 = 4'b0011;
    localparam logic [PE_NUM-1:0] MASK_ROW1 = 4'b1100;
    localparam logic [PE_NUM-1:0] MASK_COL0 = 4'b0101;
    localparam logic [PE_NUM-1:0] MASK_COL1 = 4'b1010;

    function automatic logic op_is_legal(input logic [2:0] op);
        return op <= 3'(OP_STORE);
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// -----------------------------------------------------------------------------
// Interfaces around the fetch sequencer.
//   fetch_instr_if : decoded-instruction handshake from the decoder
//                    (master = producer, slave = fetch_sequencer)
//   fetch_df_if    : control bundle to/from Data_Fetch
//                    (master = fetch_sequencer, slave = Data_Fetch)
// -----------------------------------------------------------------------------
interface fetch_instr_if;
    logic       INSTR_VALID;
    logic       INSTR_READY;
    logic [2:0] INSTR_OP;
    logic [1:0] INSTR_DIMEN;
    logic [3:0] INSTR_ADDR;
    logic [1:0] INSTR_PE;

    modport master (output INSTR_VALID, INSTR_OP, INSTR_DIMEN, INSTR_ADDR, INSTR_PE,
                    input  INSTR_READY);
    modport slave  (input  INSTR_VALID, INSTR_OP, INSTR_DIMEN, INSTR_ADDR, INSTR_PE,
                    output INSTR_READY);
endinterface

interface fetch_df_if;
    logic [1:0] DIMEN;
    logic [3:0] ADDRESS;
    logic       ADDR_RST;
    logic       ADDR_START;
    logic [1:0] PE_SEL;
    logic       PE_SEL_2x2;
    logic       PE_SEL_4;
    logic       WRADDR_START;
    logic       FETCH_DONE;
    logic       STORE_DONE;

    modport master (output DIMEN, ADDRESS, ADDR_RST, ADDR_START, PE_SEL, PE_SEL_2x2,
                           PE_SEL_4, WRADDR_START,
                    input  FETCH_DONE, STORE_DONE);
    modport slave  (input  DIMEN, ADDRESS, ADDR_RST, ADDR_START, PE_SEL, PE_SEL_2x2,
                           PE_SEL_4, WRADDR_START,
                    output FETCH_DONE, STORE_DONE);
endinterface

// File: rtl/fetch_lat_pipe.sv
// -----------------------------------------------------------------------------
// fetch_lat_pipe
// DEPTH-stage 1-bit shift register; dout is din delayed DEPTH cycles.
// Ports: CLK, RSTN (async active-low clear), din, dout.
// -----------------------------------------------------------------------------
module fetch_lat_pipe #(
    parameter int DEPTH = 1
) (
    input  logic CLK,
    input  logic RSTN,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] sr_q;
    logic [DEPTH-1:0] sr_d;
    logic [DEPTH:0]   chain;

    // Appending din below the register lets one slice cover DEPTH == 1 too.
    always_comb begin
        chain = {sr_q, din};
        sr_d  = chain[DEPTH-1:0];
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) sr_q <= '0;
        else       sr_q <= sr_d;
    end

    assign dout = sr_q[DEPTH-1];

endmodule

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
// Control stage ahead of Data_Fetch. Accepts one LOAD/STORE instruction,
// sequences ADDR_RST / ADDR_START (or WRADDR_START) until Data_Fetch reports
// completion, produces per-PE capture strobes aligned to BRAM read latency and
// pulses DONE, or ERR on an illegal opcode or watchdog expiry.
// Ports:
//   CLK, RSTN      clock, async active-low reset
//   instr          instruction handshake (slave)
//   df             Data_Fetch control bundle (master)
//   PE_LOAD_EN     per-PE capture strobes
//   BUSY           high whenever not IDLE
//   DONE / ERR     one-cycle completion / error pulses
// -----------------------------------------------------------------------------
module fetch_sequencer
    import fetch_seq_pkg::*;
#(
    parameter int READ_LAT = 1,
    parameter int WDOG_MAX = 32
) (
    input  logic                CLK,
    input  logic                RSTN,
    fetch_instr_if.slave        instr,
    fetch_df_if.master          df,
    output logic [PE_NUM-1:0]   PE_LOAD_EN,
    output logic                BUSY,
    output logic                DONE,
    output logic                ERR
);

    localparam int             WW         = $clog2(WDOG_MAX + 1);
    localparam logic [WW-1:0]  WDOG_LAST  = WW'(WDOG_MAX - 1);
    localparam logic [1:0]     DRAIN_LAST = 2'(READ_LAT - 1);

    state_e      state_q, state_d;
    logic [2:0]  op_q,    op_d;
    logic [1:0]  dimen_q, dimen_d;
    logic [3:0]  addr_q,  addr_d;
    logic [1:0]  pe_q,    pe_d;
    logic [WW-1:0] wdog_q, wdog_d;
    logic [1:0]  drain_q, drain_d;
    logic        err_q,   err_d;

    logic        addr_start;
    logic        wraddr_start;
    logic        issue_dly;
    logic [PE_NUM-1:0] mask;
    logic        is_store;
    logic        xfer_done;

    assign is_store  = (op_q == OP_STORE);
    // Completion flags are only looked at in RUN; in CLEAR they may still reflect the previous op.
    assign xfer_done = is_store ? df.STORE_DONE : df.FETCH_DONE;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        dimen_d      = dimen_q;
        addr_d       = addr_q;
        pe_d         = pe_q;
        wdog_d       = wdog_q;
        drain_d      = drain_q;
        err_d        = 1'b0;
        addr_start   = 1'b0;
        wraddr_start = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (instr.INSTR_VALID) begin
                    op_d    = instr.INSTR_OP;
                    dimen_d = instr.INSTR_DIMEN;
                    addr_d  = instr.INSTR_ADDR;
                    pe_d    = instr.INSTR_PE;
                    if (op_is_legal(instr.INSTR_OP)) state_d = ST_CLEAR;
                    else                             err_d   = 1'b1;
                end
            end
            ST_CLEAR: begin
                wdog_d  = '0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                wraddr_start = is_store;
                addr_start   = !is_store;
                // The word issued in the done cycle still counts, so completion wins over the watchdog.
                if (xfer_done) begin
                    drain_d = DRAIN_LAST;
                    state_d = is_store ? ST_DONE : ST_DRAIN;
                end else if (wdog_q == WDOG_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (drain_q == 2'd0) state_d = ST_DONE;
                else                 drain_d = drain_q - 1'b1;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Select decode from the registered instruction; stable for the whole op.
    always_comb begin
        df.PE_SEL     = 2'd0;
        df.PE_SEL_2x2 = 1'b0;
        df.PE_SEL_4   = 1'b0;
        mask          = '0;
        case (op_q)
            OP_LOAD_ALL: mask = MASK_ALL;
            OP_LOAD_ONE: begin
                df.PE_SEL                    = 2'd1;
                {df.PE_SEL_4, df.PE_SEL_2x2} = pe_q;
                mask                         = 4'b0001 << pe_q;
            end
            OP_LOAD_ROW: begin
                df.PE_SEL     = 2'd2;
                df.PE_SEL_2x2 = ~pe_q[0];
                mask          = pe_q[0] ? MASK_ROW1 : MASK_ROW0;
            end
            OP_LOAD_COL: begin
                df.PE_SEL     = 2'd3;
                df.PE_SEL_2x2 = ~pe_q[0];
                mask          = pe_q[0] ? MASK_COL1 : MASK_COL0;
            end
            OP_STORE:    df.PE_SEL = pe_q;
            default:     mask = '0;
        endcase
    end

    // NOTE: async reset clears control state and the captured fields; there is no memory array here to leave unreset.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= ST_IDLE;
            op_q    <= 3'd0;
            dimen_q <= 2'd0;
            addr_q  <= 4'd0;
            pe_q    <= 2'd0;
            wdog_q  <= '0;
            drain_q <= 2'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            dimen_q <= dimen_d;
            addr_q  <= addr_d;
            pe_q    <= pe_d;
            wdog_q  <= wdog_d;
            drain_q <= drain_d;
            err_q   <= err_d;
        end
    end

    // Issue bit delayed by the BRAM read latency marks when PE_DIN is valid.
    fetch_lat_pipe #(.DEPTH(READ_LAT)) u_lat_pipe (
        .CLK  (CLK),
        .RSTN (RSTN),
        .din  (addr_start),
        .dout (issue_dly)
    );

    assign PE_LOAD_EN        = mask & {PE_NUM{issue_dly}};
    assign df.DIMEN          = dimen_q;
    assign df.ADDRESS        = addr_q;
    assign df.ADDR_RST       = (state_q == ST_CLEAR);
    assign df.ADDR_START     = addr_start;
    assign df.WRADDR_START   = wraddr_start;
    assign instr.INSTR_READY = (state_q == ST_IDLE);
    assign BUSY              = (state_q != ST_IDLE);
    assign DONE              = (state_q == ST_DONE);
    assign ERR               = err_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
`timescale 1ns/1ps
module tb_fetch_sequencer;
    import fetch_seq_pkg::*;

    logic CLK  = 1'b0;
    logic RSTN = 1'b0;
    always #5 CLK = ~CLK;

    logic       instr_valid = 1'b0;
    logic [2:0] instr_op    = 3'd0;
    logic [1:0] instr_dimen = 2'd0;
    logic [3:0] instr_addr  = 4'd0;
    logic [1:0] instr_pe    = 2'd0;
    logic       hold_fetch_low = 1'b0;

    int checks = 0;
    int errors = 0;

    fetch_instr_if i1 ();
    fetch_instr_if i2 ();
    fetch_df_if    d1 ();
    fetch_df_if    d2 ();

    assign i1.INSTR_VALID = instr_valid;
    assign i1.INSTR_OP    = instr_op;
    assign i1.INSTR_DIMEN = instr_dimen;
    assign i1.INSTR_ADDR  = instr_addr;
    assign i1.INSTR_PE    = instr_pe;
    assign i2.INSTR_VALID = instr_valid;
    assign i2.INSTR_OP    = instr_op;
    assign i2.INSTR_DIMEN = instr_dimen;
    assign i2.INSTR_ADDR  = instr_addr;
    assign i2.INSTR_PE    = instr_pe;

    logic [3:0] en1, en2;
    logic busy1, busy2, done1, done2, err1, err2;

    fetch_sequencer #(.READ_LAT(1), .WDOG_MAX(32)) dut1 (
        .CLK(CLK), .RSTN(RSTN), .instr(i1), .df(d1),
        .PE_LOAD_EN(en1), .BUSY(busy1), .DONE(done1), .ERR(err1));

    fetch_sequencer #(.READ_LAT(2), .WDOG_MAX(32)) dut2 (
        .CLK(CLK), .RSTN(RSTN), .instr(i2), .df(d2),
        .PE_LOAD_EN(en2), .BUSY(busy2), .DONE(done2), .ERR(err2));

    // Data_Fetch stand-ins: word counter cleared by ADDR_RST, advanced per issued word.
    logic [7:0] cnt1 = 8'd0;
    logic [7:0] cnt2 = 8'd0;
    always @(posedge CLK) begin
        if (d1.ADDR_RST) cnt1 <= 8'd0;
        else if (d1.ADDR_START || d1.WRADDR_START) cnt1 <= cnt1 + 8'd1;
        if (d2.ADDR_RST) cnt2 <= 8'd0;
        else if (d2.ADDR_START || d2.WRADDR_START) cnt2 <= cnt2 + 8'd1;
    end
    assign d1.FETCH_DONE = !hold_fetch_low && (cnt1 == ((8'd2 << d1.DIMEN) - 8'd1));
    assign d2.FETCH_DONE = !hold_fetch_low && (cnt2 == ((8'd2 << d2.DIMEN) - 8'd1));
    assign d1.STORE_DONE = (cnt1 == 8'd3);
    assign d2.STORE_DONE = (cnt2 == 8'd3);

    // Every output at once, INSTR_READY in bit 0; reset value is exactly 1.
    logic [20:0] view1, view2;
    assign view1 = {d1.ADDR_RST, d1.ADDR_START, d1.WRADDR_START, d1.PE_SEL, d1.PE_SEL_2x2,
                    d1.PE_SEL_4, d1.DIMEN, d1.ADDRESS, en1, busy1, done1, err1, i1.INSTR_READY};
    assign view2 = {d2.ADDR_RST, d2.ADDR_START, d2.WRADDR_START, d2.PE_SEL, d2.PE_SEL_2x2,
                    d2.PE_SEL_4, d2.DIMEN, d2.ADDRESS, en2, busy2, done2, err2, i2.INSTR_READY};

    // Per-cycle trace: {ADDR_RST, ADDR_START, WRADDR_START, PE_LOAD_EN, DONE, ERR}
    logic [8:0] tr1 [0:63];
    logic [8:0] tr2 [0:63];
    logic [8:0] exp_v;
    // Selects captured at cycle 3: {PE_SEL, PE_SEL_4, PE_SEL_2x2, DIMEN, ADDRESS}
    logic [9:0] sel1, sel2;
    logic       rdy1_end, rdy2_end;

    function automatic logic [8:0] vec(input int k, input int r0, input int s0, input int s1,
                                       input bit wr, input int e0, input int e1,
                                       input logic [3:0] m, input int dn, input int er);
        logic s, en_on;
        s     = (k >= s0 && k <= s1);
        en_on = (k >= e0 && k <= e1);
        return {k == r0, s && !wr, s && wr, en_on ? m : 4'b0000, k == dn, k == er};
    endfunction

    // Cycle 0 is the accept cycle; sample k is taken mid-cycle k.
    task automatic run_op(input logic [2:0] op, input logic [1:0] dim, input logic [3:0] addr,
                          input logic [1:0] pe, input int n);
        @(negedge CLK);
        instr_op = op; instr_dimen = dim; instr_addr = addr; instr_pe = pe;
        instr_valid = 1'b1;
        @(posedge CLK);
        #1 instr_valid = 1'b0;
        for (int k = 1; k <= n; k++) begin
            @(negedge CLK);
            tr1[k] = {d1.ADDR_RST, d1.ADDR_START, d1.WRADDR_START, en1, done1, err1};
            tr2[k] = {d2.ADDR_RST, d2.ADDR_START, d2.WRADDR_START, en2, done2, err2};
            if (k == 3) begin
                sel1 = {d1.PE_SEL, d1.PE_SEL_4, d1.PE_SEL_2x2, d1.DIMEN, d1.ADDRESS};
                sel2 = {d2.PE_SEL, d2.PE_SEL_4, d2.PE_SEL_2x2, d2.DIMEN, d2.ADDRESS};
            end
        end
        rdy1_end = i1.INSTR_READY;
        rdy2_end = i2.INSTR_READY;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (view1 !== 21'd1) begin
            errors++; $display("FAIL reset_dut1: got %b want %b", view1, 21'd1);
        end
        checks++;
        if (view2 !== 21'd1) begin
            errors++; $display("FAIL reset_dut2: got %b want %b", view2, 21'd1);
        end
        @(negedge CLK);
        RSTN = 1'b1;
    endtask

    task automatic test_load_all();
        run_op(3'(OP_LOAD_ALL), 2'd0, 4'd4, 2'd0, 8);
        for (int k = 1; k <= 8; k++) begin
            exp_v = vec(k, 1, 2, 3, 1'b0, 3, 4, 4'b1111, 5, -1);
            checks++;
            if (tr1[k] !== exp_v) begin
                errors++; $display("FAIL load_all cyc %0d: got %b want %b", k, tr1[k], exp_v);
            end
        end
        checks++;
        if (sel1 !== {2'd0, 1'b0, 1'b0, 2'd0, 4'd4}) begin
            errors++; $display("FAIL load_all_sel: got %b want %b", sel1, {2'd0, 1'b0, 1'b0, 2'd0, 4'd4});
        end
    endtask

    task automatic test_load_row();
        run_op(3'(OP_LOAD_ROW), 2'd1, 4'd9, 2'd1, 11);
        for (int k = 1; k <= 11; k++) begin
            exp_v = vec(k, 1, 2, 5, 1'b0, 4, 7, 4'b1100, 8, -1);
            checks++;
            if (tr2[k] !== exp_v) begin
                errors++; $display("FAIL load_row_lat2 cyc %0d: got %b want %b", k, tr2[k], exp_v);
            end
            exp_v = vec(k, 1, 2, 5, 1'b0, 3, 6, 4'b1100, 7, -1);
            checks++;
            if (tr1[k] !== exp_v) begin
                errors++; $display("FAIL load_row_lat1 cyc %0d: got %b want %b", k, tr1[k], exp_v);
            end
        end
        checks++;
        if ({sel2[9:8], sel2[6:0]} !== {2'd2, 1'b0, 2'd1, 4'd9}) begin
            errors++; $display("FAIL load_row_sel: got %b want %b", {sel2[9:8], sel2[6:0]}, {2'd2, 1'b0, 2'd1, 4'd9});
        end
    endtask

    task automatic test_load_col();
        run_op(3'(OP_LOAD_COL), 2'd0, 4'd2, 2'd0, 7);
        for (int k = 1; k <= 7; k++) begin
            exp_v = vec(k, 1, 2, 3, 1'b0, 3, 4, 4'b0101, 5, -1);
            checks++;
            if (tr1[k] !== exp_v) begin
                errors++; $display("FAIL load_col cyc %0d: got %b want %b", k, tr1[k], exp_v);
            end
        end
        checks++;
        if ({sel1[9:8], sel1[6:0]} !== {2'd3, 1'b1, 2'd0, 4'd2}) begin
            errors++; $display("FAIL load_col_sel: got %b want %b", {sel1[9:8], sel1[6:0]}, {2'd3, 1'b1, 2'd0, 4'd2});
        end
    endtask

    task automatic test_store();
        run_op(3'(OP_STORE), 2'd2, 4'd7, 2'd3, 9);
        for (int k = 1; k <= 9; k++) begin
            exp_v = vec(k, 1, 2, 5, 1'b1, -1, -1, 4'b0000, 6, -1);
            checks++;
            if (tr1[k] !== exp_v) begin
                errors++; $display("FAIL store_lat1 cyc %0d: got %b want %b", k, tr1[k], exp_v);
            end
            checks++;
            if (tr2[k] !== exp_v) begin
                errors++; $display("FAIL store_lat2 cyc %0d: got %b want %b", k, tr2[k], exp_v);
            end
        end
        checks++;
        if ({sel1[9:8], sel1[5:0]} !== {2'd3, 2'd2, 4'd7}) begin
            errors++; $display("FAIL store_sel: got %b want %b", {sel1[9:8], sel1[5:0]}, {2'd3, 2'd2, 4'd7});
        end
    endtask

    task automatic test_illegal();
        run_op(3'd6, 2'd1, 4'd3, 2'd0, 6);
        for (int k = 1; k <= 6; k++) begin
            exp_v = vec(k, -1, -1, -1, 1'b0, -1, -1, 4'b0000, -1, 1);
            checks++;
            if (tr1[k] !== exp_v) begin
                errors++; $display("FAIL illegal_dut1 cyc %0d: got %b want %b", k, tr1[k], exp_v);
            end
            checks++;
            if (tr2[k] !== exp_v) begin
                errors++; $display("FAIL illegal_dut2 cyc %0d: got %b want %b", k, tr2[k], exp_v);
            end
        end
    endtask

    task automatic test_watchdog();
        hold_fetch_low = 1'b1;
        run_op(3'(OP_LOAD_ALL), 2'd3, 4'd0, 2'd0, 38);
        hold_fetch_low = 1'b0;
        for (int k = 1; k <= 38; k++) begin
            exp_v = vec(k, 1, 2, 33, 1'b0, 3, 34, 4'b1111, -1, 34);
            checks++;
            if (tr1[k] !== exp_v) begin
                errors++; $display("FAIL wdog_lat1 cyc %0d: got %b want %b", k, tr1[k], exp_v);
            end
            exp_v = vec(k, 1, 2, 33, 1'b0, 4, 35, 4'b1111, -1, 34);
            checks++;
            if (tr2[k] !== exp_v) begin
                errors++; $display("FAIL wdog_lat2 cyc %0d: got %b want %b", k, tr2[k], exp_v);
            end
        end
        checks++;
        if ({rdy1_end, rdy2_end} !== 2'b11) begin
            errors++; $display("FAIL wdog_ready: got %b want 11", {rdy1_end, rdy2_end});
        end
    endtask

    task automatic test_reset_mid_run();
        logic saw_done;
        run_op(3'(OP_LOAD_ALL), 2'd3, 4'd11, 2'd0, 5);
        #2 RSTN = 1'b0;
        #1;
        checks++;
        if (view1 !== 21'd1) begin
            errors++; $display("FAIL midrun_reset_dut1: got %b want %b", view1, 21'd1);
        end
        checks++;
        if (view2 !== 21'd1) begin
            errors++; $display("FAIL midrun_reset_dut2: got %b want %b", view2, 21'd1);
        end
        repeat (2) @(negedge CLK);
        RSTN = 1'b1;
        saw_done = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            saw_done = saw_done | done1 | done2 | busy1 | busy2;
        end
        checks++;
        if (saw_done !== 1'b0) begin
            errors++; $display("FAIL midrun_no_done: got %b want 0", saw_done);
        end
        run_op(3'(OP_LOAD_ONE), 2'd0, 4'd5, 2'd2, 7);
        for (int k = 1; k <= 7; k++) begin
            exp_v = vec(k, 1, 2, 3, 1'b0, 3, 4, 4'b0100, 5, -1);
            checks++;
            if (tr1[k] !== exp_v) begin
                errors++; $display("FAIL load_one cyc %0d: got %b want %b", k, tr1[k], exp_v);
            end
        end
        checks++;
        if (sel1 !== {2'd1, 1'b1, 1'b0, 2'd0, 4'd5}) begin
            errors++; $display("FAIL load_one_sel: got %b want %b", sel1, {2'd1, 1'b1, 1'b0, 2'd0, 4'd5});
        end
    endtask

    initial begin
        test_reset();
        test_load_all();
        test_load_row();
        test_load_col();
        test_store();
        test_illegal();
        test_watchdog();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
